// File: rtl/game_pkg.sv
// Shared definitions for the racing-game sequencer: state encoding, default
// tuning parameters and overlay colours.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_CRASH = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int DEF_HIT_THRESH   = 4;
    localparam int DEF_CRASH_FRAMES = 60;
    localparam int DEF_BLINK_FRAMES = 8;
    localparam int DEF_SCORE_W      = 16;
    localparam int DEF_HIT_W        = 8;

    localparam logic [11:0] BLACK = 12'h000;
    localparam logic [11:0] WHITE = 12'hFFF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game sequencer: qualifies collisions once per frame, runs IDLE/PLAY/CRASH/OVER,
// drives overlay enable and mover freeze, and tracks score and high score.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int HIT_THRESH   = DEF_HIT_THRESH,
    parameter int CRASH_FRAMES = DEF_CRASH_FRAMES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int HIT_W        = DEF_HIT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               collosion_flag,
    input  logic               frame_tick,
    input  logic               start_btn,
    output logic [1:0]         game_state,
    output logic               game_over_en,
    output logic               freeze,
    output logic               crash_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int FRAME_MAX = (CRASH_FRAMES > BLINK_FRAMES) ? CRASH_FRAMES : BLINK_FRAMES;
    localparam int FRAME_W   = $clog2(FRAME_MAX + 1);

    game_state_e        state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_q, blink_d;
    logic               start_q, start_d;
    logic               game_over_en_q, game_over_en_d;
    logic               freeze_q, freeze_d;
    logic               crash_pulse_q, crash_pulse_d;
    logic [SCORE_W-1:0] high_score_q, high_score_d;

    logic [HIT_W-1:0]   hit_cnt;
    logic [SCORE_W-1:0] score_cnt;
    logic               start_rise;
    logic               crash_det;
    logic               hit_clr;
    logic               score_clr;
    logic               score_en;
    logic [FRAME_W-1:0] frame_next;

    // Event qualification feeding both counters and the FSM.
    always_comb begin
        start_d    = start_btn;
        start_rise = start_btn & ~start_q;
        crash_det  = (state_q == ST_PLAY) && frame_tick && (hit_cnt >= HIT_W'(HIT_THRESH));
        hit_clr    = (state_q != ST_PLAY) || frame_tick;
        score_clr  = start_rise && ((state_q == ST_IDLE) || (state_q == ST_OVER));
        score_en   = (state_q == ST_PLAY) && frame_tick && !crash_det;
        frame_next = frame_cnt_q + FRAME_W'(1);
    end

    sat_counter #(.W(HIT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hit_clr),
        .en    (collosion_flag),
        .cnt   (hit_cnt)
    );

    sat_counter #(.W(SCORE_W)) u_score_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .en    (score_en),
        .cnt   (score_cnt)
    );

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;
        high_score_d  = high_score_q;
        crash_pulse_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (crash_det) begin
                    state_d       = ST_CRASH;
                    frame_cnt_d   = '0;
                    blink_d       = 1'b1;
                    crash_pulse_d = 1'b1;
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    frame_cnt_d = frame_next;
                    if ((frame_next % FRAME_W'(BLINK_FRAMES)) == '0) begin
                        blink_d = ~blink_q;
                    end
                    if (frame_next == FRAME_W'(CRASH_FRAMES)) begin
                        state_d      = ST_OVER;
                        high_score_d = (score_cnt > high_score_q) ? score_cnt : high_score_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs follow the next state so they line up with game_state.
        freeze_d       = (state_d != ST_PLAY);
        game_over_en_d = (state_d == ST_OVER) || ((state_d == ST_CRASH) && blink_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            frame_cnt_q    <= '0;
            blink_q        <= 1'b0;
            start_q        <= 1'b0;
            game_over_en_q <= 1'b0;
            freeze_q       <= 1'b1;
            crash_pulse_q  <= 1'b0;
            high_score_q   <= '0;
        end else begin
            state_q        <= state_d;
            frame_cnt_q    <= frame_cnt_d;
            blink_q        <= blink_d;
            start_q        <= start_d;
            game_over_en_q <= game_over_en_d;
            freeze_q       <= freeze_d;
            crash_pulse_q  <= crash_pulse_d;
            high_score_q   <= high_score_d;
        end
    end

    assign game_state   = state_q;
    assign game_over_en = game_over_en_q;
    assign freeze       = freeze_q;
    assign crash_pulse  = crash_pulse_q;
    assign score        = score_cnt;
    assign high_score   = high_score_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: vector table for reset/idle/play/crash entry,
// hand-written sequences for the crash blink, restarts and mid-crash reset.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        collosion_flag = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic [1:0]  game_state;
    logic        game_over_en;
    logic        freeze;
    logic        crash_pulse;
    logic [15:0] score;
    logic [15:0] high_score;

    game_state_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .collosion_flag (collosion_flag),
        .frame_tick     (frame_tick),
        .start_btn      (start_btn),
        .game_state     (game_state),
        .game_over_en   (game_over_en),
        .freeze         (freeze),
        .crash_pulse    (crash_pulse),
        .score          (score),
        .high_score     (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, sb, fl, tk;
        int   st, goe, frz, cp, sc, hs;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic rst, input logic sb, input logic fl, input logic tk,
                                input int st, input int goe, input int cp, input int sc, input int hs);
        vec_t v;
        v.rst = rst; v.sb = sb; v.fl = fl; v.tk = tk;
        v.st = st; v.goe = goe; v.cp = cp; v.sc = sc; v.hs = hs;
        v.frz = (st == 1) ? 0 : 1;
        return v;
    endfunction

    // Overlay is on for CRASH frames 0-7, off for 8-15, and so on.
    function automatic int blink_of(input int k);
        return ((k / 8) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        vec_t e;
        reset          = v.rst;
        start_btn      = v.sb;
        collosion_flag = v.fl;
        frame_tick     = v.tk;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".state"}, int'(game_state), e.st);
        check({tag, ".game_over_en"}, int'(game_over_en), e.goe);
        check({tag, ".freeze"}, int'(freeze), e.frz);
        check({tag, ".crash_pulse"}, int'(crash_pulse), e.cp);
        check({tag, ".score"}, int'(score), e.sc);
        check({tag, ".high_score"}, int'(high_score), e.hs);
    endtask

    // 60 CRASH frames. With sb_hold=0 the button is pulsed (including once on a
    // tick) and must be ignored; with sb_hold=1 it stays high throughout.
    task automatic crash_frames(input string tag, input bit sb_hold, input int sc,
                                input int hs_prev, input int hs_new);
        logic sb;
        for (int k = 1; k <= 60; k++) begin
            sb = sb_hold ? 1'b1 : ((k % 10) == 3);
            step(mk(0, sb, 0, 0, 2, blink_of(k - 1), 0, sc, hs_prev), $sformatf("%s.f%0d.idle", tag, k));
            sb = sb_hold ? 1'b1 : (k == 20);
            if (k < 60)
                step(mk(0, sb, 0, 1, 2, blink_of(k), 0, sc, hs_prev), $sformatf("%s.f%0d.tick", tag, k));
            else
                step(mk(0, sb, 0, 1, 3, 1, 0, sc, hs_new), $sformatf("%s.f%0d.tick", tag, k));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset, then five idle frames with no start.
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));
        end
        // Start, then ten clean frames.
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, k - 1, 0));
            tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, k, 0));
        end
        // Three hits, with a fourth flag on the tick itself that must not count.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 10, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 11, 0));
        // Three hits again: counter must have restarted from zero.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 11, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 12, 0));
        // Four hits: crash, one-cycle pulse, score frozen.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 12, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 1, 12, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Run 1 ends: blink pattern, ignored start pulses, high score captured.
        crash_frames("crash1", 1'b0, 12, 0, 12);
        step(mk(0, 0, 0, 0, 3, 1, 0, 12, 12), "over1.a");
        step(mk(0, 0, 0, 0, 3, 1, 0, 12, 12), "over1.b");

        // Restart coincident with a frame tick: no score for that tick.
        step(mk(0, 1, 0, 1, 1, 0, 0, 0, 12), "restart.tick");
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 12), "run2.f1.idle");
        step(mk(0, 1, 0, 1, 1, 0, 0, 1, 12), "run2.f1.tick");
        step(mk(0, 1, 0, 0, 1, 0, 0, 1, 12), "run2.f2.idle");
        step(mk(0, 1, 0, 1, 1, 0, 0, 2, 12), "run2.f2.tick");
        for (int i = 0; i < 4; i++) step(mk(0, 1, 1, 0, 1, 0, 0, 2, 12), $sformatf("run2.hit%0d", i));
        step(mk(0, 1, 0, 1, 2, 1, 1, 2, 12), "run2.crash");

        // Lower score leaves high score alone; held button never retriggers.
        crash_frames("crash2", 1'b1, 2, 12, 12);
        for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 0, 3, 1, 0, 2, 12), $sformatf("over2.held%0d", i));
        step(mk(0, 0, 0, 0, 3, 1, 0, 2, 12), "over2.release");
        step(mk(0, 1, 0, 0, 1, 0, 0, 0, 12), "run3.start");
        step(mk(0, 0, 0, 1, 1, 0, 0, 1, 12), "run3.f1.tick");
        for (int i = 0; i < 4; i++) step(mk(0, 0, 1, 0, 1, 0, 0, 1, 12), $sformatf("run3.hit%0d", i));
        step(mk(0, 0, 0, 1, 2, 1, 1, 1, 12), "run3.crash");
        for (int k = 1; k <= 10; k++) step(mk(0, 0, 0, 1, 2, blink_of(k), 0, 1, 12), $sformatf("crash3.f%0d", k));

        // One-cycle reset mid-crash clears everything, high score included.
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), "crash3.reset");
        step(mk(0, 0, 0, 1, 0, 0, 0, 0, 0), "post_reset.idle");

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
